// File: rtl/ms6205_pkg.sv
// Shared types and constants for the MS6205 bus receiver.
package ms6205_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    BUSY
  } state_t;

  localparam int RAM_DEPTH = 256;
  localparam int ADDR_W    = 8;

  // Idle levels: strobes are active low, marker idles low.
  localparam logic STROBE_RST = 1'b1;
  localparam logic MARKER_RST = 1'b0;

endpackage

// File: rtl/ms6205_bus_receiver_strobe_sync.sv
// Synchroniser for one asynchronous control line: STAGES flops, a level register,
// an edge-detect register and registered rise/fall pulses.
module strobe_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int FLUSH = STAGES + 2;
  localparam int FW    = $clog2(FLUSH + 1);

  logic [STAGES-1:0] sync_reg;
  logic              level_reg;
  logic              edge_reg;
  logic              rise_reg;
  logic              fall_reg;
  logic [FW-1:0]     flush_reg;
  logic              armed;

  // Pulses stay masked until real input data has flushed the pipeline, so a line
  // already at its active level when reset releases never looks like an edge.
  assign armed = (flush_reg == FW'(FLUSH));

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg  <= {STAGES{RST_VAL}};
      level_reg <= RST_VAL;
      edge_reg  <= RST_VAL;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      flush_reg <= '0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      level_reg <= sync_reg[STAGES-1];
      edge_reg  <= level_reg;
      rise_reg  <= armed & level_reg & ~edge_reg;
      fall_reg  <= armed & ~level_reg & edge_reg;
      if (!armed) begin
        flush_reg <= flush_reg + FW'(1);
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ms6205_bus_receiver.sv
// MS6205 write-interface responder: synchronised strobes capture the emulator bus
// into a 256-byte character RAM with an auto-incrementing pointer and ready handshake.
module ms6205_bus_receiver
  import ms6205_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYCLES = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [7:0]           emulData,
  input  logic                 write_addr_n,
  input  logic                 write_data_n,
  input  logic                 marker,
  output logic                 ready,
  output logic [7:0]           cur_addr,
  input  logic [7:0]           rd_addr,
  output logic [7:0]           rd_data,
  output logic [7:0]           marker_pos,
  output logic                 marker_valid,
  output logic [CNT_WIDTH-1:0] write_count,
  output logic                 protocol_err,
  input  logic                 err_clr
);

  // Bus delay matches the strobe path (sync stages + level register).
  localparam int DLY = SYNC_STAGES + 1;
  localparam int BW  = $clog2(BUSY_CYCLES + 1);

  logic [DLY-1:0][7:0] bus_dly_reg;
  logic [7:0]          bus_aligned;

  logic addr_fe, data_fe, marker_re;
  logic addr_lvl, data_lvl, marker_lvl;
  logic addr_re, data_re, marker_fe;

  state_t                state_reg, state_next;
  logic [BW-1:0]         busy_reg, busy_next;
  logic [ADDR_W-1:0]     cur_addr_reg, cur_addr_next;
  logic [7:0]            wdata_reg, wdata_next;
  logic [CNT_WIDTH-1:0]  write_count_reg, write_count_next;
  logic                  protocol_err_reg, protocol_err_next;
  logic [ADDR_W-1:0]     marker_pos_reg, marker_pos_next;
  logic                  marker_valid_reg, marker_valid_next;
  logic                  ram_we;
  logic                  err_set;

  logic [7:0]            mem [RAM_DEPTH];
  logic [7:0]            rd_data_reg;

  strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(STROBE_RST)) u_addr_sync (
    .clk(Clk), .srst(Rst), .din(write_addr_n),
    .level(addr_lvl), .rise(addr_re), .fall(addr_fe)
  );

  strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(STROBE_RST)) u_data_sync (
    .clk(Clk), .srst(Rst), .din(write_data_n),
    .level(data_lvl), .rise(data_re), .fall(data_fe)
  );

  strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MARKER_RST)) u_marker_sync (
    .clk(Clk), .srst(Rst), .din(marker),
    .level(marker_lvl), .rise(marker_re), .fall(marker_fe)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, addr_lvl, data_lvl, marker_lvl, addr_re, data_re, marker_fe};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus_dly_reg <= '0;
    end else begin
      bus_dly_reg[0] <= emulData;
      for (int i = 1; i < DLY; i++) begin
        bus_dly_reg[i] <= bus_dly_reg[i-1];
      end
    end
  end

  assign bus_aligned = bus_dly_reg[DLY-1];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg        <= IDLE;
      busy_reg         <= '0;
      cur_addr_reg     <= '0;
      wdata_reg        <= '0;
      write_count_reg  <= '0;
      protocol_err_reg <= 1'b0;
      marker_pos_reg   <= '0;
      marker_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      busy_reg         <= busy_next;
      cur_addr_reg     <= cur_addr_next;
      wdata_reg        <= wdata_next;
      write_count_reg  <= write_count_next;
      protocol_err_reg <= protocol_err_next;
      marker_pos_reg   <= marker_pos_next;
      marker_valid_reg <= marker_valid_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    busy_next         = busy_reg;
    cur_addr_next     = cur_addr_reg;
    wdata_next        = wdata_reg;
    write_count_next  = write_count_reg;
    marker_pos_next   = marker_pos_reg;
    marker_valid_next = marker_valid_reg;
    ram_we            = 1'b0;
    err_set           = 1'b0;
    ready             = 1'b0;

    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (addr_fe && data_fe) begin
          err_set = 1'b1;
        end else if (addr_fe) begin
          cur_addr_next = bus_aligned;
        end else if (data_fe) begin
          wdata_next = bus_aligned;
          state_next = WRITE;
        end
      end
      WRITE: begin
        err_set       = addr_fe | data_fe;
        ram_we        = 1'b1;
        cur_addr_next = cur_addr_reg + 8'd1;
        if (write_count_reg != '1) begin
          write_count_next = write_count_reg + CNT_WIDTH'(1);
        end
        busy_next  = BW'(BUSY_CYCLES);
        state_next = BUSY;
      end
      BUSY: begin
        err_set   = addr_fe | data_fe;
        busy_next = busy_reg - BW'(1);
        if (busy_reg == BW'(1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Marker sees the register value, so during WRITE it takes the pre-increment pointer.
    if (marker_re) begin
      marker_pos_next   = cur_addr_reg;
      marker_valid_next = 1'b1;
    end

    protocol_err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : protocol_err_reg);
  end

  always_ff @(posedge Clk) begin
    if (ram_we) begin
      mem[cur_addr_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign cur_addr     = cur_addr_reg;
  assign rd_data      = rd_data_reg;
  assign marker_pos   = marker_pos_reg;
  assign marker_valid = marker_valid_reg;
  assign write_count  = write_count_reg;
  assign protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_ms6205_bus_receiver.sv
// Directed/randomised bench for ms6205_bus_receiver against a byte-array reference model.
module tb_ms6205_bus_receiver;

  localparam int S    = 2;
  localparam int BUSY = 16;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    emulData;
  logic          write_addr_n;
  logic          write_data_n;
  logic          marker;
  logic          ready;
  logic [7:0]    cur_addr;
  logic [7:0]    rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    marker_pos;
  logic          marker_valid;
  logic [CW-1:0] write_count;
  logic          protocol_err;
  logic          err_clr;

  int checks = 0;
  int errors = 0;

  // Reference model: what the display memory and pointer should hold.
  logic [7:0]    ref_ram [256];
  logic [7:0]    ref_cur;
  logic [CW-1:0] ref_count;

  always #5 clk = ~clk;

  ms6205_bus_receiver #(.SYNC_STAGES(S), .BUSY_CYCLES(BUSY), .CNT_WIDTH(CW)) dut (
    .Clk(clk), .Rst(rst), .emulData(emulData),
    .write_addr_n(write_addr_n), .write_data_n(write_data_n), .marker(marker),
    .ready(ready), .cur_addr(cur_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .marker_pos(marker_pos), .marker_valid(marker_valid), .write_count(write_count),
    .protocol_err(protocol_err), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] d);
    ref_ram[ref_cur] = d;
    ref_cur = ref_cur + 8'd1;
    if (ref_count != '1) ref_count = ref_count + 1'b1;
  endtask

  task automatic check_ram(input logic [7:0] a);
    rd_addr = a;
    @(negedge clk);
    check($sformatf("ram[%02h]", a), rd_data, ref_ram[a]);
  endtask

  task automatic addr_write(input logic [7:0] a);
    emulData = a;
    repeat (4) @(negedge clk);
    write_addr_n = 1'b0;
    repeat (3) @(negedge clk);
    write_addr_n = 1'b1;
    emulData = 8'($urandom);
    repeat (5) @(negedge clk);
    ref_cur = a;
    check("addr_write", cur_addr, ref_cur);
    $display("addr write 0x%02h -> cur_addr 0x%02h", a, cur_addr);
  endtask

  task automatic data_write(input logic [7:0] d);
    logic [7:0] old_addr;
    logic [7:0] addr_e1;
    logic [7:0] addr_e2;
    int first_low;
    int lows;
    old_addr = ref_cur;
    first_low = -1;
    lows = 0;
    addr_e1 = 'x;
    addr_e2 = 'x;
    emulData = d;
    repeat (4) @(negedge clk);
    write_data_n = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!ready) begin
        if (first_low < 0) first_low = n;
        lows++;
      end
      if (n == S + 2) addr_e1 = cur_addr;
      if (n == S + 3) addr_e2 = cur_addr;
      if (n == 2) begin
        write_data_n = 1'b1;
        emulData = 8'($urandom);
      end
    end
    model_write(d);
    check("ready_fall_cycle", first_low, S + 2);
    check("ready_low_len", lows, BUSY + 1);
    check("addr_during_write", addr_e1, old_addr);
    check("addr_after_write", addr_e2, ref_cur);
    check("write_count", write_count, ref_count);
    check_ram(old_addr);
    $display("data write 0x%02h at 0x%02h, ready low %0d cycles, count %0d", d, old_addr, lows, write_count);
  endtask

  logic [7:0] d;
  logic [7:0] a;
  logic [7:0] old_cur;
  int highs;

  initial begin
    rst = 1'b1;
    emulData = 8'h00;
    write_addr_n = 1'b1;
    write_data_n = 1'b1;
    marker = 1'b0;
    rd_addr = 8'h00;
    err_clr = 1'b0;
    ref_cur = 8'h00;
    ref_count = '0;
    for (int i = 0; i < 256; i++) ref_ram[i] = 'x;

    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_cur_addr", cur_addr, 8'h00);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_marker_pos", marker_pos, 8'h00);
    check("rst_marker_valid", marker_valid, 1'b0);
    check("rst_write_count", write_count, '0);
    check("rst_protocol_err", protocol_err, 1'b0);
    $display("reset state sampled");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Basic address + two data writes.
    addr_write(8'h10);
    data_write(8'h41);
    data_write(8'h42);
    check("cur_after_two", cur_addr, 8'h12);
    check("count_after_two", write_count, 16'd2);

    // Pointer wrap at 0xFF.
    addr_write(8'hFF);
    data_write(8'h55);
    data_write(8'h66);
    check("wrap_cur", cur_addr, 8'h01);
    check_ram(8'hFF);
    check_ram(8'h00);

    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      addr_write(a);
      data_write(8'($urandom));
      data_write(8'($urandom));
    end

    // Data strobe while BUSY: second write is dropped and flagged.
    addr_write(8'h10);
    ref_ram[8'h11] = 8'h42;
    d = 8'($urandom);
    old_cur = ref_cur;
    emulData = d;
    repeat (4) @(negedge clk);
    write_data_n = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 2) begin
        write_data_n = 1'b1;
        emulData = 8'($urandom);
      end
      if (n == 5) write_data_n = 1'b0;
      if (n == 7) write_data_n = 1'b1;
    end
    model_write(d);
    check("busy_err", protocol_err, 1'b1);
    check("busy_count", write_count, ref_count);
    check("busy_cur", cur_addr, ref_cur);
    check_ram(old_cur);
    check_ram(ref_cur);
    $display("data strobe during BUSY: err %0b count %0d", protocol_err, write_count);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", protocol_err, 1'b0);
    $display("err_clr pulse: err %0b", protocol_err);

    // Both strobes in the same cycle.
    old_cur = ref_cur;
    emulData = 8'($urandom);
    repeat (4) @(negedge clk);
    write_addr_n = 1'b0;
    write_data_n = 1'b0;
    highs = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ready) highs++;
      if (n == 2) begin
        write_addr_n = 1'b1;
        write_data_n = 1'b1;
      end
    end
    check("both_ready_high", highs, 30);
    check("both_err", protocol_err, 1'b1);
    check("both_cur", cur_addr, old_cur);
    check("both_count", write_count, ref_count);
    check_ram(old_cur);
    $display("simultaneous strobes: err %0b cur_addr 0x%02h", protocol_err, cur_addr);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);

    // Marker capture and scan-out read.
    addr_write(8'h2A);
    data_write(8'($urandom));
    addr_write(8'h2A);
    marker = 1'b1;
    repeat (8) @(negedge clk);
    check("marker_pos", marker_pos, 8'h2A);
    check("marker_valid", marker_valid, 1'b1);
    marker = 1'b0;
    check_ram(8'h2A);
    $display("marker at 0x%02h valid %0b", marker_pos, marker_valid);

    // Reset in the middle of BUSY, with an error pending.
    d = 8'($urandom);
    old_cur = ref_cur;
    emulData = d;
    repeat (4) @(negedge clk);
    write_data_n = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      if (n == 2) begin
        write_data_n = 1'b1;
        emulData = 8'($urandom);
      end
      if (n == 3) write_addr_n = 1'b0;
      if (n == 5) write_addr_n = 1'b1;
    end
    check("pre_rst_busy", ready, 1'b0);
    check("pre_rst_err", protocol_err, 1'b1);
    ref_ram[old_cur] = d;
    rst = 1'b1;
    @(negedge clk);
    check("busy_rst_ready", ready, 1'b1);
    check("busy_rst_cur", cur_addr, 8'h00);
    check("busy_rst_count", write_count, '0);
    check("busy_rst_err", protocol_err, 1'b0);
    check("busy_rst_marker_valid", marker_valid, 1'b0);
    $display("reset during BUSY: ready %0b cur_addr 0x%02h", ready, cur_addr);
    ref_cur = 8'h00;
    ref_count = '0;

    // Data strobe held low through reset release.
    write_data_n = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    highs = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready) highs++;
    end
    check("held_ready_high", highs, 20);
    check("held_count", write_count, ref_count);
    check("held_cur", cur_addr, ref_cur);
    $display("strobe held through reset: count %0d", write_count);
    write_data_n = 1'b1;
    repeat (8) @(negedge clk);
    check_ram(old_cur);
    data_write(8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
